mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of ports; any value >= 2, not restricted to powers of two.
REQ-002 SHALL have parameter TAG_DEPTH, default 4: number of read-tag FIFO entries, i.e. the maximum number of outstanding reads.
REQ-003 SHALL have parameter CNT_W, default 16: width of each grant counter.
REQ-004 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, synchronous active-high reset); one clock, reset synchronous and active-high.
REQ-005 SHALL have ports wr_req_i (in, N, per-port write request), wr_addr_i (in, N x ADDR_W) and wr_data_i (in, N x BLOCK_BITS).
REQ-006 SHALL have port wr_gnt_o (in this order: out, N, one-hot write grant).
REQ-007 SHALL have ports rd_req_i (in, N, per-port read request) and rd_addr_i (in, N x ADDR_W).
REQ-008 SHALL have port rd_gnt_o (out, N, one-hot read grant).
REQ-009 SHALL have memory-side outputs mem_we_o (1), mem_waddr_o (ADDR_W), mem_wdata_o (BLOCK_BITS), mem_re_o (1) and mem_raddr_o (ADDR_W).
REQ-010 SHALL have memory-side inputs mem_rvalid_i (1) and mem_rdata_i (BLOCK_BITS).
REQ-011 SHALL have ports rd_rvalid_o (out, N, one-hot response valid) and rd_rdata_o (out, BLOCK_BITS, shared by all ports).
REQ-012 SHALL have ports err_o (out, 1, sticky protocol error) and tag_full_o (out, 1, read-tag FIFO full).
REQ-013 SHALL have ports wr_cnt_o and rd_cnt_o (out, N x CNT_W, per-port grant counters).

Function
REQ-014 Write and read paths SHALL be arbitrated independently; a write grant and a read grant MAY occur in the same cycle.
REQ-015 Each path SHALL use work-conserving round-robin arbitration:
- the search starts at the priority pointer and proceeds upward, wrapping N-1 -> 0;
- the first requesting port is granted;
- idle ports are skipped with no bubble cycles.
REQ-016 Grants SHALL be combinational in the cycle of the request (zero latency):
- a requester holds req and address/data stable until it sees gnt;
- gnt and req high in the same cycle completes the transfer.
REQ-017 After a grant to port k, that path's pointer SHALL become (k+1) mod N on the next edge; with no grant, the pointer SHALL hold.
REQ-018 mem_we_o SHALL equal OR(wr_req_i).
REQ-019 mem_waddr_o/mem_wdata_o SHALL mux the granted port's inputs; they are don't-care when mem_we_o=0.
REQ-020 mem_re_o SHALL be high exactly when a read grant is issued.
REQ-021 mem_raddr_o SHALL mux the granted port's rd_addr_i.
REQ-022 Each read grant SHALL push the granted port index into an in-order tag FIFO of TAG_DEPTH entries.
REQ-023 Each mem_rvalid_i SHALL pop the FIFO head.
REQ-024 On a pop, rd_rvalid_o[head] SHALL be driven high combinationally and rd_rdata_o SHALL equal mem_rdata_i.
REQ-025 When the FIFO is full, no read grant SHALL be issued, unless mem_rvalid_i pops in the same cycle (simultaneous push and pop allowed).
REQ-026 While reads are blocked by a full FIFO, the read pointer SHALL hold.
REQ-027 mem_rvalid_i with an empty FIFO SHALL leave rd_rvalid_o at zero and set err_o.
REQ-028 err_o SHALL stay high until rst.
REQ-029 Counters SHALL increment by 1 per grant to their port and SHALL wrap modulo 2^CNT_W.

Reset
REQ-030 While rst is high, both pointers SHALL be 0 (port 0 has first priority after reset).
REQ-031 While rst is high, the tag FIFO SHALL be emptied and err_o, tag_full_o and all counters SHALL be 0.
REQ-032 While rst is high, wr_gnt_o, rd_gnt_o, mem_we_o, mem_re_o and rd_rvalid_o SHALL be forced to 0.
REQ-033 Reset mid-operation SHALL discard outstanding tags; the memory is reset on the same rst.

Configuration
REQ-034 With macro MEM_ARB_STATS_EN defined, wr_cnt_o/rd_cnt_o SHALL count grants per REQ-029.
REQ-035 With MEM_ARB_STATS_EN undefined, no counter flops SHALL exist and the counter ports SHALL remain present, tied to 0.

Structure
REQ-036 ADDR_W and BLOCK_BITS SHALL come from the shared mem_pkg.
REQ-037 A port-index typedef (width $clog2(N)) SHALL be added to mem_pkg.
REQ-038 The arbitration logic SHALL be a sub-module rr_arb (parameter N; inputs req and advance; outputs one-hot gnt and granted index), instantiated once for the write path and once for the read path.
REQ-039 The tag FIFO SHALL be inline.

Verification
REQ-040 N=4, wr_req=4'b1111 held 8 cycles after reset -> write grants to ports 0,1,2,3,0,1,2,3.
REQ-041 wr_req=4'b1001 with pointer 1 -> port 3 granted first, then port 0, with no idle cycles.
REQ-042 Read ports 2 then 0 granted, then two mem_rvalid pulses with data 0xA, 0xB -> rd_rvalid_o[2] with 0xA, then rd_rvalid_o[0] with 0xB.
REQ-043 TAG_DEPTH=4, 4 reads granted with no responses -> tag_full_o=1 and rd_gnt_o=0; a 5th request granted in the same cycle as a response.
REQ-044 mem_rvalid_i pulse with the FIFO empty -> rd_rvalid_o=0 and err_o=1, held until rst.
REQ-045 rst asserted mid-burst with MEM_ARB_STATS_EN defined -> all counters 0 and the next grant goes to the lowest requesting port; with the macro undefined, counters are 0 throughout.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-subsystem constants: address/block widths and the default port-index type.
// port_idx_t is sized for the default port count; parameterised blocks derive their own index width from N.
package mem_pkg;
    localparam int ADDR_W     = 16;
    localparam int BLOCK_BITS = 32;
    localparam int NUM_PORTS  = 4;

    typedef logic [$clog2(NUM_PORTS)-1:0] port_idx_t;
endpackage

// File: rtl/rr_arb.sv
// Work-conserving round-robin arbiter: search from the pointer upward with wrap, grant the first requester.
// Latency: grant is combinational in the request cycle. Backpressure: caller masks req; pointer moves only on advance with a grant.
// Pointer becomes (granted+1) mod N after an advancing grant, otherwise holds.
module rr_arb #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found)
            ptr_d = (idx == IDX_W'(N - 1)) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// N-port memory arbiter: independent round-robin write and read paths, in-order read-tag FIFO routes responses.
// Latency: zero-cycle grants; responses routed combinationally on mem_rvalid_i. Backpressure: reads stall while tag FIFO full
// (unless a response frees a slot the same cycle). Grant counters exist only when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int N         = 4,
    parameter int TAG_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            wr_req_i,
    input  logic [N*ADDR_W-1:0]     wr_addr_i,
    input  logic [N*BLOCK_BITS-1:0] wr_data_i,
    output logic [N-1:0]            wr_gnt_o,
    input  logic [N-1:0]            rd_req_i,
    input  logic [N*ADDR_W-1:0]     rd_addr_i,
    output logic [N-1:0]            rd_gnt_o,
    output logic                    mem_we_o,
    output logic [ADDR_W-1:0]       mem_waddr_o,
    output logic [BLOCK_BITS-1:0]   mem_wdata_o,
    output logic                    mem_re_o,
    output logic [ADDR_W-1:0]       mem_raddr_o,
    input  logic                    mem_rvalid_i,
    input  logic [BLOCK_BITS-1:0]   mem_rdata_i,
    output logic [N-1:0]            rd_rvalid_o,
    output logic [BLOCK_BITS-1:0]   rd_rdata_o,
    output logic                    err_o,
    output logic                    tag_full_o,
    output logic [N*CNT_W-1:0]      wr_cnt_o,
    output logic [N*CNT_W-1:0]      rd_cnt_o
);
    localparam int IDX_W = $clog2(N);
    localparam int TP_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CT_W  = $clog2(TAG_DEPTH + 1);

    logic [N-1:0]     wr_req_ok, rd_req_ok;
    logic [N-1:0]     wr_gnt, rd_gnt;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    logic [IDX_W-1:0] tag_q [TAG_DEPTH];
    logic [IDX_W-1:0] tag_d [TAG_DEPTH];
    logic [TP_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CT_W-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             empty, full, push, pop, rd_allow;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CT_W'(TAG_DEPTH));
    assign pop       = mem_rvalid_i && !empty && !rst;
    assign rd_allow  = !full || pop;
    assign wr_req_ok = wr_req_i & {N{!rst}};
    assign rd_req_ok = rd_req_i & {N{rd_allow && !rst}};
    assign push      = |rd_gnt;

    rr_arb #(.N(N)) u_wr_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (wr_req_ok),
        .advance (!rst),
        .gnt     (wr_gnt),
        .idx     (wr_idx)
    );

    rr_arb #(.N(N)) u_rd_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (rd_req_ok),
        .advance (!rst),
        .gnt     (rd_gnt),
        .idx     (rd_idx)
    );

    assign wr_gnt_o    = wr_gnt;
    assign rd_gnt_o    = rd_gnt;
    assign mem_we_o    = (|wr_req_i) && !rst;
    assign mem_waddr_o = wr_addr_i[wr_idx*ADDR_W +: ADDR_W];
    assign mem_wdata_o = wr_data_i[wr_idx*BLOCK_BITS +: BLOCK_BITS];
    assign mem_re_o    = push;
    assign mem_raddr_o = rd_addr_i[rd_idx*ADDR_W +: ADDR_W];
    assign rd_rdata_o  = mem_rdata_i;
    assign err_o       = err_q && !rst;
    assign tag_full_o  = full && !rst;

    always_comb begin
        rd_rvalid_o = '0;
        if (pop) rd_rvalid_o[tag_q[head_q]] = 1'b1;
    end

    always_comb begin
        tag_d  = tag_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        err_d  = err_q | (mem_rvalid_i && empty);
        if (push) begin
            tag_d[tail_q] = rd_idx;
            tail_d = (tail_q == TP_W'(TAG_DEPTH - 1)) ? '0 : tail_q + 1'b1;
        end
        if (pop)
            head_d = (head_q == TP_W'(TAG_DEPTH - 1)) ? '0 : head_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Tag payloads need no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            tag_q  <= tag_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [N-1:0][CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

    always_comb begin
        for (int p = 0; p < N; p++) begin
            wr_cnt_d[p] = wr_cnt_q[p] + CNT_W'(wr_gnt[p]);
            rd_cnt_d[p] = rd_cnt_q[p] + CNT_W'(rd_gnt[p]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_cnt_o = wr_cnt_q;
    assign rd_cnt_o = rd_cnt_q;
`else
    assign wr_cnt_o = '0;
    assign rd_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter (N=4, TAG_DEPTH=4) against a queue-based reference model.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int NP = 4;
    localparam int TD = 4;
    localparam int CW = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NP-1:0]            wr_req_i, rd_req_i;
    logic [NP*ADDR_W-1:0]     wr_addr_i, rd_addr_i;
    logic [NP*BLOCK_BITS-1:0] wr_data_i;
    logic [NP-1:0]            wr_gnt_o, rd_gnt_o, rd_rvalid_o;
    logic                     mem_we_o, mem_re_o, mem_rvalid_i, err_o, tag_full_o;
    logic [ADDR_W-1:0]        mem_waddr_o, mem_raddr_o;
    logic [BLOCK_BITS-1:0]    mem_wdata_o, mem_rdata_i, rd_rdata_o;
    logic [NP*CW-1:0]         wr_cnt_o, rd_cnt_o;

    mem_port_arbiter #(.N(NP), .TAG_DEPTH(TD), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
        .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
        .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .rd_rvalid_o(rd_rvalid_o), .rd_rdata_o(rd_rdata_o),
        .err_o(err_o), .tag_full_o(tag_full_o),
        .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_wp = 0, m_rp = 0;
    int m_q[$];
    bit m_err = 0;
    int m_wc[NP], m_rc[NP];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int ptr, input logic [NP-1:0] req);
        for (int i = 0; i < NP; i++) begin
            int k;
            k = (ptr + i) % NP;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [63:0] pack_cnt(input int c[NP]);
        logic [63:0] v;
        v = '0;
`ifdef MEM_ARB_STATS_EN
        for (int p = 0; p < NP; p++) v[p*CW +: CW] = c[p][CW-1:0];
`endif
        return v;
    endfunction

    task automatic step(input logic r, input logic [NP-1:0] wr, input logic [NP-1:0] rd, input logic rv);
        int  wk, rk;
        bit  popd, allow, was_empty;
        logic [NP-1:0] exp_rv;
        @(negedge clk);
        rst          = r;
        wr_req_i     = wr;
        rd_req_i     = rd;
        mem_rvalid_i = rv;
        for (int p = 0; p < NP; p++) begin
            wr_addr_i[p*ADDR_W +: ADDR_W]         = ADDR_W'($urandom);
            rd_addr_i[p*ADDR_W +: ADDR_W]         = ADDR_W'($urandom);
            wr_data_i[p*BLOCK_BITS +: BLOCK_BITS] = BLOCK_BITS'($urandom);
        end
        mem_rdata_i = BLOCK_BITS'($urandom);
        #1;
        if (r) begin
            check("rst_wr_gnt", 64'(wr_gnt_o), 0);
            check("rst_rd_gnt", 64'(rd_gnt_o), 0);
            check("rst_we", 64'(mem_we_o), 0);
            check("rst_re", 64'(mem_re_o), 0);
            check("rst_rvalid", 64'(rd_rvalid_o), 0);
            check("rst_err", 64'(err_o), 0);
            check("rst_full", 64'(tag_full_o), 0);
            check("rst_wr_cnt", 64'(wr_cnt_o), 0);
            check("rst_rd_cnt", 64'(rd_cnt_o), 0);
            m_wp = 0; m_rp = 0; m_q.delete(); m_err = 0;
            for (int p = 0; p < NP; p++) begin m_wc[p] = 0; m_rc[p] = 0; end
            return;
        end
        check("err", 64'(err_o), 64'(m_err));
        check("tag_full", 64'(tag_full_o), 64'(m_q.size() == TD));
        check("wr_cnt", 64'(wr_cnt_o), pack_cnt(m_wc));
        check("rd_cnt", 64'(rd_cnt_o), pack_cnt(m_rc));

        wk = pick(m_wp, wr);
        check("wr_gnt", 64'(wr_gnt_o), (wk >= 0) ? 64'(1) << wk : 64'(0));
        check("mem_we", 64'(mem_we_o), 64'(|wr));
        if (wk >= 0) begin
            check("waddr", 64'(mem_waddr_o), 64'(wr_addr_i[wk*ADDR_W +: ADDR_W]));
            check("wdata", 64'(mem_wdata_o), 64'(wr_data_i[wk*BLOCK_BITS +: BLOCK_BITS]));
        end

        was_empty = (m_q.size() == 0);
        popd      = rv && !was_empty;
        exp_rv    = '0;
        if (popd) exp_rv[m_q[0]] = 1'b1;
        check("rd_rvalid", 64'(rd_rvalid_o), 64'(exp_rv));
        if (popd) check("rd_rdata", 64'(rd_rdata_o), 64'(mem_rdata_i));

        allow = (m_q.size() < TD) || popd;
        rk = allow ? pick(m_rp, rd) : -1;
        check("rd_gnt", 64'(rd_gnt_o), (rk >= 0) ? 64'(1) << rk : 64'(0));
        check("mem_re", 64'(mem_re_o), 64'(rk >= 0));
        if (rk >= 0) check("raddr", 64'(mem_raddr_o), 64'(rd_addr_i[rk*ADDR_W +: ADDR_W]));

        if (wk >= 0) begin m_wp = (wk + 1) % NP; m_wc[wk] = (m_wc[wk] + 1) % 65536; end
        if (popd) void'(m_q.pop_front());
        if (rk >= 0) begin m_q.push_back(rk); m_rp = (rk + 1) % NP; m_rc[rk] = (m_rc[rk] + 1) % 65536; end
        if (rv && was_empty) m_err = 1;
    endtask

    initial begin
        rst = 1'b1; wr_req_i = '0; rd_req_i = '0; mem_rvalid_i = 1'b0;
        wr_addr_i = '0; rd_addr_i = '0; wr_data_i = '0; mem_rdata_i = '0;

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        // all four writers contending: strict rotation 0..3
        for (int i = 0; i < 8; i++) step(0, 4'hF, 0, 0);
        // move write pointer to 1, then ports 3 and 0 back to back
        step(0, 4'b0001, 0, 0);
        step(0, 4'b1001, 0, 0);
        step(0, 4'b1001, 0, 0);
        // reads from 2 then 0, responses return in order
        step(0, 0, 4'b0100, 0);
        step(0, 0, 4'b0001, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        // fill the tag FIFO, stall, then grant alongside a response
        for (int i = 0; i < 6; i++) step(0, 0, 4'hF, 0);
        step(0, 0, 4'hF, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 4'h3, 0, 0);
        // reset mid-burst, then lowest requester wins
        step(1, 4'hF, 4'hF, 0);
        step(0, 4'b0110, 4'b1100, 0);
        step(0, 4'b0110, 4'b1100, 0);

        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 99) == 0),
                 NP'($urandom), NP'($urandom),
                 ($urandom_range(0, 9) < 4));
        end
        step(1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
